// File: rtl/noc2_req_arbiter.sv
// noc2_req_arbiter
// Packet-atomic round-robin arbiter sharing one val/rdy NoC2 request port
// between two val/rdy requesters. Flits pass through combinationally; only
// the packet-tracking state, priority and statistics counters are stored.

module noc2_req_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_LSB    = 22,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic                  in0_val,
    output logic                  in0_rdy,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic                  in1_val,
    output logic                  in1_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic                  owner,
    output logic                  busy,
    output logic [31:0]           pkt_cnt0,
    output logic [31:0]           pkt_cnt1
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t               state;
    logic                 hold;
    logic                 prio;
    logic                 owner_q;
    logic                 busy_q;
    logic [LEN_WIDTH-1:0] rem;
    logic [31:0]          cnt0;
    logic [31:0]          cnt1;

    logic                 sel;
    logic                 beat;
    logic [LEN_WIDTH-1:0] hdr_len;

    // Requester selection. owner_q always records the last selection, so it
    // doubles as the latched index for both a held header and a locked packet.
    always_comb begin
        sel = owner_q;
        if (reset) begin
            sel = 1'b0;
        end else if (state == LOCK || hold) begin
            sel = owner_q;
        end else if (in0_val && in1_val) begin
            sel = prio;
        end else if (in0_val) begin
            sel = 1'b0;
        end else if (in1_val) begin
            sel = 1'b1;
        end
    end

    assign out_data = sel ? in1_data : in0_data;
    assign out_val  = sel ? in1_val  : in0_val;
    assign in0_rdy  = ~sel & out_rdy;
    assign in1_rdy  =  sel & out_rdy;
    assign beat     = out_val & out_rdy;
    assign hdr_len  = out_data[LEN_LSB +: LEN_WIDTH];

    assign owner    = sel;
    assign busy     = busy_q;
    assign pkt_cnt0 = cnt0;
    assign pkt_cnt1 = cnt1;

    // Packet tracking FSM: header handling in IDLE, payload countdown in LOCK.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            hold    <= 1'b0;
            prio    <= 1'b0;
            owner_q <= 1'b0;
            busy_q  <= 1'b0;
            rem     <= '0;
            cnt0    <= '0;
            cnt1    <= '0;
        end else begin
            owner_q <= sel;
            case (state)
                IDLE: begin
                    if (beat) begin
                        hold <= 1'b0;
                        if (sel) begin
                            cnt1 <= cnt1 + 32'd1;
                        end else begin
                            cnt0 <= cnt0 + 32'd1;
                        end
                        if (hdr_len == '0) begin
                            prio <= ~sel;
                        end else begin
                            rem    <= hdr_len;
                            state  <= LOCK;
                            busy_q <= 1'b1;
                        end
                    end else if (out_val) begin
                        hold <= 1'b1;
                    end
                end
                LOCK: begin
                    if (beat) begin
                        rem <= rem - 1'b1;
                        if (rem == LEN_WIDTH'(1)) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            prio   <= ~sel;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc2_req_arbiter.sv
// Testbench for noc2_req_arbiter: directed vector table, hand-written
// multi-cycle sequences and randomized packet traffic, all checked against
// a packet-level reference model.

module tb_noc2_req_arbiter;

    localparam int DW = 64;
    localparam int LL = 22;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in0_data;
    logic          in0_val;
    logic          in0_rdy;
    logic [DW-1:0] in1_data;
    logic          in1_val;
    logic          in1_rdy;
    logic [DW-1:0] out_data;
    logic          out_val;
    logic          out_rdy;
    logic          owner;
    logic          busy;
    logic [31:0]   pkt_cnt0;
    logic [31:0]   pkt_cnt1;

    always #5 clk = ~clk;

    noc2_req_arbiter #(
        .DATA_WIDTH (DW),
        .LEN_LSB    (LL),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in0_data (in0_data),
        .in0_val  (in0_val),
        .in0_rdy  (in0_rdy),
        .in1_data (in1_data),
        .in1_val  (in1_val),
        .in1_rdy  (in1_rdy),
        .out_data (out_data),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .owner    (owner),
        .busy     (busy),
        .pkt_cnt0 (pkt_cnt0),
        .pkt_cnt1 (pkt_cnt1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    int          m_src;     // requester whose packet body is in flight, -1 if none
    int          m_left;    // payload beats still owed by that packet
    int          m_prio;    // requester favoured on the next tie
    int          m_hold;    // requester whose header is waiting for out_rdy, -1 if none
    int          m_last;    // most recent selection
    int unsigned m_cnt[2];

    task automatic model_reset();
        m_src = -1; m_left = 0; m_prio = 0; m_hold = -1; m_last = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
    endtask

    function automatic int exp_sel();
        if (reset)                return 0;
        if (m_src >= 0)           return m_src;
        if (m_hold >= 0)          return m_hold;
        if (in0_val && in1_val)   return m_prio;
        if (in0_val)              return 0;
        if (in1_val)              return 1;
        return m_last;
    endfunction

    task automatic model_check();
        int            es;
        logic          ev;
        logic [DW-1:0] ed;
        es = exp_sel();
        ev = (es == 1) ? in1_val : in0_val;
        ed = (es == 1) ? in1_data : in0_data;
        chk("owner",    owner,    es);
        chk("out_val",  out_val,  ev);
        chk("out_data", out_data, ed);
        chk("in0_rdy",  in0_rdy,  (es == 0) && out_rdy);
        chk("in1_rdy",  in1_rdy,  (es == 1) && out_rdy);
        chk("busy",     busy,     m_src >= 0);
        chk("pkt_cnt0", pkt_cnt0, m_cnt[0]);
        chk("pkt_cnt1", pkt_cnt1, m_cnt[1]);
    endtask

    task automatic model_update();
        int            es;
        logic          ev;
        logic [DW-1:0] ed;
        int            len;
        if (reset) begin
            model_reset();
            return;
        end
        es = exp_sel();
        ev = (es == 1) ? in1_val : in0_val;
        ed = (es == 1) ? in1_data : in0_data;
        m_last = es;
        if (ev && out_rdy) begin
            if (m_src < 0) begin
                m_cnt[es] = m_cnt[es] + 1;
                m_hold = -1;
                len = int'(ed[LL +: LW]);
                if (len == 0) m_prio = 1 - es;
                else begin
                    m_src  = es;
                    m_left = len;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_prio = 1 - m_src;
                    m_src  = -1;
                end
            end
        end else if (m_src < 0 && ev) begin
            m_hold = es;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [DW-1:0] hdr(input int len, input logic [31:0] tag);
        logic [DW-1:0] h;
        h = {32'hC0DE_0000, tag};
        h[LL +: LW] = len[LW-1:0];
        return h;
    endfunction

    function automatic logic [DW-1:0] pay(input int idx);
        return {32'hDA7A_0000, idx[31:0]};
    endfunction

    task automatic drive(input logic v0, input logic [DW-1:0] d0,
                         input logic v1, input logic [DW-1:0] d1, input logic rdy);
        in0_val = v0; in0_data = d0;
        in1_val = v1; in1_data = d1;
        out_rdy = rdy;
        #1;
    endtask

    task automatic tick();
        model_check();
        model_update();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          v0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [DW-1:0] d1;
        logic          rdy;
        logic          e_val;
        logic          e_sel;
        logic          e_r0;
        logic          e_r1;
        logic          e_busy;
        int unsigned   e_c0;
        int unsigned   e_c1;
    } vec_t;

    vec_t tbl[14];

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    task automatic gen_pkt(input int r);
        int len;
        len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 40)) : int'($urandom_range(0, 4));
        if (r == 0) q0.push_back(hdr(len, $urandom));
        else        q1.push_back(hdr(len, $urandom));
        for (int i = 0; i < len; i++) begin
            if (r == 0) q0.push_back({$urandom, $urandom});
            else        q1.push_back({$urandom, $urandom});
        end
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n0, n1, cyc;
        logic a0, a1;

        // Vector table: {v0, d0, v1, d1, out_rdy} -> {out_val, owner, in0_rdy, in1_rdy, busy, cnt0, cnt1}
        tbl[0]  = '{1'b1, hdr(0, 1), 1'b1, hdr(0, 2), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[1]  = '{1'b1, hdr(2, 3), 1'b1, hdr(0, 2), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0};
        tbl[2]  = '{1'b1, hdr(2, 3), 1'b0, '0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1};
        tbl[3]  = '{1'b1, pay(1),    1'b0, '0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1};
        tbl[4]  = '{1'b1, pay(2),    1'b1, hdr(0, 4), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1};
        tbl[5]  = '{1'b0, '0,        1'b1, hdr(0, 4), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2, 1};
        tbl[6]  = '{1'b0, '0,        1'b1, hdr(0, 6), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 2};
        tbl[7]  = '{1'b1, hdr(0, 7), 1'b1, hdr(0, 6), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 2};
        tbl[8]  = '{1'b0, hdr(0, 7), 1'b1, hdr(0, 6), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 2};
        tbl[9]  = '{1'b1, hdr(0, 7), 1'b1, hdr(0, 6), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2, 2};
        tbl[10] = '{1'b1, hdr(0, 7), 1'b0, '0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 3};
        tbl[11] = '{1'b0, '0,        1'b0, '0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 3};
        tbl[12] = '{1'b0, '0,        1'b1, hdr(0, 8), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3, 3};
        tbl[13] = '{1'b0, '0,        1'b0, '0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3, 4};

        reset = 1'b1;
        in0_val = 1'b0; in0_data = '0; in1_val = 1'b0; in1_data = '0; out_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].rdy);
            chk($sformatf("tbl%0d_out_val", i),  out_val,  tbl[i].e_val);
            chk($sformatf("tbl%0d_owner", i),    owner,    tbl[i].e_sel);
            chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_sel ? tbl[i].d1 : tbl[i].d0);
            chk($sformatf("tbl%0d_in0_rdy", i),  in0_rdy,  tbl[i].e_r0);
            chk($sformatf("tbl%0d_in1_rdy", i),  in1_rdy,  tbl[i].e_r1);
            chk($sformatf("tbl%0d_busy", i),     busy,     tbl[i].e_busy);
            chk($sformatf("tbl%0d_cnt0", i),     pkt_cnt0, tbl[i].e_c0);
            chk($sformatf("tbl%0d_cnt1", i),     pkt_cnt1, tbl[i].e_c1);
            tick();
        end

        // Contention: in0 sends L=4, in1 raises valid on in0's second beat.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, (k == 0) ? hdr(4, 32'h40) : pay(k), (k >= 1), hdr(2, 32'h41), 1'b1);
            chk("contention_in1_rdy_low", in1_rdy, 1'b0);
            chk("contention_owner_in0", owner, 1'b0);
            tick();
        end
        drive(1'b1, hdr(0, 32'h42), 1'b1, hdr(2, 32'h41), 1'b1);
        chk("contention_handover_rdy", in1_rdy, 1'b1);
        chk("contention_handover_val", out_val, 1'b1);
        tick();
        for (int k = 1; k <= 2; k++) begin
            drive(1'b1, hdr(0, 32'h42), 1'b1, pay(100 + k), 1'b1);
            chk("contention_in0_blocked", in0_rdy, 1'b0);
            tick();
        end
        drive(1'b1, hdr(0, 32'h42), 1'b0, '0, 1'b1);
        chk("contention_in0_after", in0_rdy, 1'b1);
        tick();

        // Maximum length: in1 sends L=255 under random stalls, in0 contends throughout.
        n0 = 0; n1 = 0; cyc = 0;
        while (n1 < 256 && cyc < 3000) begin
            drive(n1 > 0, hdr(0, 32'h55), 1'b1, (n1 == 0) ? hdr(255, 32'h56) : pay(n1),
                  $urandom_range(0, 3) != 0);
            if (in1_val && in1_rdy) n1++;
            if (in0_val && in0_rdy) n0++;
            tick();
            cyc++;
        end
        chk("maxlen_in1_beats", n1, 256);
        chk("maxlen_in0_interleaved", n0, 0);
        drive(1'b1, hdr(0, 32'h55), 1'b0, '0, 1'b1);
        chk("maxlen_busy_after", busy, 1'b0);
        chk("maxlen_in0_next", in0_rdy, 1'b1);
        tick();

        // Reset during the third beat of an L=6 packet.
        for (int k = 0; k < 3; k++) begin
            reset = (k == 2);
            drive(1'b1, (k == 0) ? hdr(6, 32'h60) : pay(k), 1'b0, '0, 1'b1);
            tick();
        end
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnt0", pkt_cnt0, 0);
        chk("rst_cnt1", pkt_cnt1, 0);
        chk("rst_owner", owner, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, hdr(0, 32'h61), 1'b1);
        chk("rst_new_in1_rdy", in1_rdy, 1'b1);
        chk("rst_new_out_val", out_val, 1'b1);
        tick();
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        chk("rst_new_cnt1", pkt_cnt1, 1);
        tick();

        // Random packet traffic from both requesters.
        a0 = 1'b0; a1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (q0.size() == 0 && $urandom_range(0, 3) == 0) gen_pkt(0);
            if (q1.size() == 0 && $urandom_range(0, 3) == 0) gen_pkt(1);
            if (!a0 && q0.size() > 0 && $urandom_range(0, 2) != 0) a0 = 1'b1;
            if (!a1 && q1.size() > 0 && $urandom_range(0, 2) != 0) a1 = 1'b1;
            drive(a0, (q0.size() > 0) ? q0[0] : '0, a1, (q1.size() > 0) ? q1[0] : '0,
                  $urandom_range(0, 4) != 0);
            if (in0_val && in0_rdy) begin
                void'(q0.pop_front());
                a0 = 1'b0;
            end
            if (in1_val && in1_rdy) begin
                void'(q1.pop_front());
                a1 = 1'b0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
